// File: rtl/ex_muldiv_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_muldiv_ctrl_pkg : op codes, FSM states and op-class helpers        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ex_muldiv_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_md_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_md_step : one shift-add multiply or restoring-divide iteration     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ex_md_step #(
  parameter int N = 31
) (
  input  logic [2*N+1:0] pair_in,
  input  logic [N:0]     operand,
  input  logic           bit_in,
  input  logic           is_div,
  output logic [2*N+1:0] pair_out
);

  localparam int W = N + 1;

  // The remainder is always below the divisor, so the shifted remainder is
  // below twice the divisor and a W+1-bit trial keeps a valid sign bit.
  logic [W:0] trial;

  always_comb begin
    trial    = '0;
    pair_out = '0;
    if (is_div) begin
      trial = {pair_in[2*N+1:W], bit_in} - {1'b0, operand};
      if (!trial[W]) begin
        pair_out = {trial[N:0], pair_in[N-1:0], 1'b1};
      end else begin
        pair_out = {pair_in[2*N:W], bit_in, pair_in[N-1:0], 1'b0};
      end
    end else begin
      pair_out = {pair_in[2*N:0], 1'b0} + (bit_in ? {{W{1'b0}}, operand} : {2*W{1'b0}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_muldiv_ctrl : iterative mul/div sequencer owning HI/LO             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int N       = 31,
  parameter int MD_ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       md_start,
  input  logic [2:0] md_op,
  input  logic [N:0] src_a,
  input  logic [N:0] src_b,
  input  logic       md_flush,
  output logic       busy,
  output logic       md_stall,
  output logic       done,
  output logic [N:0] hi,
  output logic [N:0] lo
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(MD_ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_ITER - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [N:0]      a_mag_q, a_mag_d;
  logic [N:0]      b_mag_q, b_mag_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            div_q, div_d;
  logic [N:0]      hi_q, hi_d;
  logic [N:0]      lo_q, lo_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [2*W-1:0]  step_pair;
  logic            start_sa, start_sb;
  logic [N:0]      a_raw;
  logic [N:0]      quot, rem;
  logic [2*W-1:0]  prod;

  // Dividend / multiplier bits are consumed MSB first.
  ex_md_step #(.N(N)) u_step (
    .pair_in  (acc_q),
    .operand  (b_mag_q),
    .bit_in   (a_mag_q[CNT_LAST - cnt_q]),
    .is_div   (div_q),
    .pair_out (step_pair)
  );

  assign start_sa = md_is_signed(md_op) & src_a[N];
  assign start_sb = md_is_signed(md_op) & src_b[N];
  assign a_raw    = sa_q ? -a_mag_q : a_mag_q;
  assign quot     = (sa_q ^ sb_q) ? -acc_q[N:0] : acc_q[N:0];
  assign rem      = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  assign prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (md_start) begin
          if (md_is_arith(md_op)) begin
            a_mag_d = start_sa ? -src_a : src_a;
            b_mag_d = start_sb ? -src_b : src_b;
            sa_d    = start_sa;
            sb_d    = start_sb;
            div_d   = (md_op == MD_DIV) || (md_op == MD_DIVU);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = src_a;
          end else if (md_op == MD_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      S_RUN: begin
        acc_d = step_pair;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div_q) begin
          // Divide by zero bypasses sign fix-up and returns the dividend in HI.
          if (b_mag_q == '0) begin
            lo_d = '1;
            hi_d = a_raw;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (md_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = busy_q | (md_start & md_is_arith(md_op));

endmodule
`default_nettype wire
